// File: rtl/sipo_deserializer_if.sv
// Bundle of the deserializer's serial-side inputs and parallel-side outputs.
// Optional macro PARITY_CHECK_EN adds the parity_err output.
// master: the serial source / consumer side; slave: the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sin_valid;
    logic             sin;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport master (
        output start, sin_valid, sin,
        input  pout, pout_valid, busy, overrun
`ifdef PARITY_CHECK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  start, sin_valid, sin,
        output pout, pout_valid, busy, overrun
`ifdef PARITY_CHECK_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer feeding a d_latch capture bank.
// pout is registered and held; pout_valid is a one-cycle latch enable.
// Optional macro PARITY_CHECK_EN: one extra even-parity bit per frame,
// reported on parity_err. The interface WIDTH must match this WIDTH.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    sipo_deserializer_if.slave  sif
);
    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] pout_q;
    logic             pout_valid_q;
    logic             busy_q;
    logic             overrun_q;
`ifdef PARITY_CHECK_EN
    logic             parity_err_q;
`endif

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] word_d;
    logic             fin;

    // Next shift value, completed word and frame-completion condition.
    always_comb begin
        shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], sif.sin}
                                   : {sif.sin, shift_q[WIDTH-1:1]};
`ifdef PARITY_CHECK_EN
        word_d  = shift_q;
        fin     = (state_q == PARITY) && sif.sin_valid;
`else
        word_d  = shift_d;
        fin     = (state_q == SHIFT) && sif.sin_valid && (count_q == LAST);
`endif
    end

    // Frame FSM with registered outputs; completion beats a same-cycle start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            pout_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        shift_q <= '0;
                    end
                end
                default: begin
                    if (fin) begin
                        pout_q       <= word_d;
                        pout_valid_q <= 1'b1;
`ifdef PARITY_CHECK_EN
                        parity_err_q <= (^shift_q) ^ sif.sin;
`endif
                        count_q      <= '0;
                        shift_q      <= '0;
                        if (sif.start) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (sif.start) begin
                        overrun_q <= 1'b1;
                        count_q   <= '0;
                        shift_q   <= '0;
                        state_q   <= SHIFT;
                    end else if (sif.sin_valid) begin
                        shift_q <= shift_d;
`ifdef PARITY_CHECK_EN
                        if (count_q == LAST) begin
                            count_q <= '0;
                            state_q <= PARITY;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
`else
                        count_q <= count_q + CW'(1);
`endif
                    end
                end
            endcase
        end
    end

    assign sif.pout       = pout_q;
    assign sif.pout_valid = pout_valid_q;
    assign sif.busy       = busy_q;
    assign sif.overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
    assign sif.parity_err = parity_err_q;
`endif
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in parallel-out deserializer that feeds the d_latch capture bank.
- Collects a framed serial bitstream into a WIDTH-bit word.
- Presents the word on a registered parallel bus with a one-cycle strobe. The strobe drives the enable of the downstream d_latch array.
- Parallel data is stable for the whole time the strobe is high, so the downstream latches capture a clean word while transparent.

Parameters:
- WIDTH, 8, word width in bits; legal range >= 2.
- MSB_FIRST, 1, 1: first received bit lands in pout[WIDTH-1]; 0: first received bit lands in pout[0].

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  frame-start strobe; begins a new word.
- sin_valid  in  1  qualifies sin for the current cycle.
- sin  in  1  serial data bit.
- pout  out  WIDTH  last completed word (registered).
- pout_valid  out  1  one-cycle pulse when pout is updated; used as downstream latch enable.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky flag: a frame was abandoned by a new start.

Behaviour:
- Reset: with rst_n=0 at a rising edge, state=IDLE, bit count=0, shift reg=0, pout=0, pout_valid=0, busy=0, overrun=0. Reset overrides all other inputs, including mid-frame; the partial word is discarded.
- States: IDLE, SHIFT (plus PARITY when PARITY_CHECK_EN is defined). busy = (state != IDLE), registered.
- IDLE:
  - sin_valid/sin are ignored.
  - start=1 -> SHIFT, count=0, shift reg cleared.
  - The start cycle carries no data; sin in the start cycle is not captured.
- SHIFT, each edge with sin_valid=1:
  - The bit enters the shift reg per MSB_FIRST and count increments.
  - sin_valid=0 holds all state; there is no timeout.
- Completion: the edge that samples bit number WIDTH (count == WIDTH-1 with sin_valid=1):
  - loads pout with the assembled word;
  - sets pout_valid=1 for exactly one cycle;
  - returns state to IDLE (busy=0 in the same cycle pout_valid=1).
  - Latency: pout/pout_valid are visible the cycle after the last bit is sampled.
- pout changes only at completion and holds its value otherwise, including through idle periods.
- start=1 in SHIFT before completion:
  - The partial word is abandoned, with no pout_valid.
  - overrun is set to 1 (sticky until reset).
  - count and shift reg are cleared and the state stays SHIFT.
  - That cycle's sin is not captured.
- start=1 in the same cycle as the final bit:
  - The word completes normally (pout_valid=1).
  - The next state is SHIFT with count=0, and overrun is not set.
- Only one pout_valid pulse per completed frame; back-to-back frames produce pulses at least one cycle apart.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - After the WIDTH data bits, the state goes to PARITY and waits for one more sin_valid bit (even parity).
  - Completion occurs on the parity bit: pout loads the data word and pout_valid pulses.
  - Extra output parity_err (out, 1) = XOR of the WIDTH data bits and the parity bit. It is registered, updated only at completion and held otherwise; reset value 0.
  - pout is updated even on a parity error.
  - start during PARITY counts as an abandoned frame (overrun=1).
- Not defined: no PARITY state and no parity_err port; completion occurs on data bit WIDTH.

Test Plan:
All scenarios use WIDTH=8, MSB_FIRST=1 unless stated.
1. Reset: rst_n=0 for 2 edges while start=1, sin_valid=1, sin=1 -> pout=8'h00, pout_valid=0, busy=0, overrun=0.
2. Single frame: start pulse, then 8 consecutive valid bits 1,0,1,0,0,1,1,0 -> pout=8'hA6, pout_valid high exactly one cycle, the cycle after bit 8; busy falls in that same cycle.
3. Gaps: same frame with sin_valid=0 for 3 cycles between bits 4 and 5 -> pout=8'hA6, single pout_valid pulse, busy high throughout the gap.
4. Restart: start, 3 valid bits, start again, then 0,0,1,1,1,1,0,0 -> overrun=1 and stays 1, pout=8'h3C, exactly one pout_valid pulse.
5. Bit order and reset mid-frame:
   - MSB_FIRST=0 instance, bits 1,0,1,0,0,1,1,0 -> pout=8'h65.
   - Then start, 5 valid bits, rst_n=0 for 1 edge -> busy=0, pout=8'h00.
   - Next frame of eight 1s -> pout=8'hFF.
6. PARITY_CHECK_EN: data 8'hA6 then parity bit 0 -> pout_valid=1, parity_err=0. Repeat with parity bit 1 -> pout=8'hA6, parity_err=1.
